ctr_timer_sched: RTL and testbench

Round-robin scheduler that shares one 16-bit loadable up-counter among NREQ requesters, each needing a timed interval of LEN count-enable ticks. The block grants the counter to one requester at a time, loads it, gates its count enable from a shared TICK strobe, detects the end of the interval, and pulses DONE back to the owner. It sits between request/interval sources (e.g. protocol timeout logic) and the counter datapath, replacing per-requester timers.

---
 rtl/ctr_timer_sched_pkg.sv | 16 +
 rtl/ctr_timer_sched_ld_counter.sv | 45 ++++
 rtl/ctr_timer_sched.sv | 174 +++++++++++++++++
 tb/tb_ctr_timer_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_timer_sched_pkg.sv
// Shared definitions for the counter timer scheduler.
// Holds the FSM state encodings and the default requester count and
// counter width used by ctr_timer_sched and its counter sub-module.
package ctr_timer_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/ctr_timer_sched_ld_counter.sv
// Loadable up-counter shared by all requesters of ctr_timer_sched.
// Load has priority over count enable.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset, clears the count
//   ld_i   load d_i into the counter
//   ce_i   count enable, increments by one
//   d_i    load value
//   q_o    current count
module ctr_timer_sched_ld_counter
  import ctr_timer_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = d_i;
    end else if (ce_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/ctr_timer_sched.sv
// Round-robin scheduler sharing one loadable up-counter among NREQ
// requesters. The winner's interval length is latched at grant, the
// counter is cleared, advanced on each tick, and the owner receives a
// one-cycle done pulse when the count reaches its interval.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   asynchronous active-high reset
//   req_i   per-requester request level (held until done, drop to abort)
//   len_i   per-requester interval, slice i = len_i[i*WIDTH +: WIDTH]
//   tick_i  count-enable strobe
//   gnt_o   one-hot owner of the counter (registered)
//   done_o  one-cycle completion pulse to the owner (registered)
//   busy_o  high whenever the scheduler is not idle
//   q_o     elapsed ticks of the current (or last) interval
module ctr_timer_sched
  import ctr_timer_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] len_i,
  input  logic                  tick_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       done_o,
  output logic                  busy_o,
  output logic [WIDTH-1:0]      q_o
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // First requesting index found searching upward from ptr, wrapping mod NREQ.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] win;
    logic [IDXW-1:0] ci;
    logic            found;
    win   = ptr;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      ci = IDXW'((int'(ptr) + off) % NREQ);
      if (!found && req[ci]) begin
        win   = ci;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (i == IDXW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] len_sel;
  logic [IDXW-1:0]  pick;
  logic             cnt_ld;
  logic             cnt_ce;
  logic [WIDTH-1:0] cnt_q;

  always_comb begin
    pick    = rr_pick(req_i, ptr_q);
    len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IDXW'(i)) begin
        len_sel = len_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_ld  = 1'b0;
    cnt_ce  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          idx_d   = pick;
          gnt_d   = onehot(pick);
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_ld = 1'b1;
        if (len_q == '0) begin
          state_d = FIN;
          done_d  = onehot(idx_q);
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // An owner dropping its request wins over a completing tick.
        if (!req_i[idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_idx(idx_q);
        end else begin
          cnt_ce = tick_i;
          // Counter reaches len_q on the same edge that enters FIN,
          // so it stops there and never wraps.
          if (tick_i && (cnt_q == len_q - WIDTH'(1))) begin
            state_d = FIN;
            done_d  = onehot(idx_q);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = next_idx(idx_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  // Interval length is captured only at grant; later LEN changes are ignored.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && |req_i) begin
      len_q <= len_sel;
    end
  end

  ctr_timer_sched_ld_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ld_i  (cnt_ld),
    .ce_i  (cnt_ce),
    .d_i   ('0),
    .q_o   (cnt_q)
  );

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign busy_o = (state_q != IDLE);
  assign q_o    = cnt_q;

endmodule

// File: tb/tb_ctr_timer_sched.sv
module tb_ctr_timer_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic                  clk_i;
  logic                  rst_i;
  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] len_i;
  logic                  tick_i;
  logic [NREQ-1:0]       gnt_o;
  logic [NREQ-1:0]       done_o;
  logic                  busy_o;
  logic [WIDTH-1:0]      q_o;

  logic tick_force;
  logic tick_sparse;
  int   cyc;

  typedef struct {
    logic [NREQ-1:0]  done;
    logic [WIDTH-1:0] q;
    int               cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp;
  int   n_bad;

  ctr_timer_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .len_i  (len_i),
    .tick_i (tick_i),
    .gnt_o  (gnt_o),
    .done_o (done_o),
    .busy_o (busy_o),
    .q_o    (q_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  assign tick_i = tick_force | (tick_sparse & ((cyc % 3) == 0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_done(input int idx, input int bound);
    bit seen;
    seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      step();
      if (done_o[idx]) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: requester %0d no DONE within %0d cycles", idx, bound);
    end
  endtask

  task automatic push(input logic [NREQ-1:0] d, input logic [WIDTH-1:0] q, input int c);
    exp_t e;
    e.done = d;
    e.q    = q;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  // Monitor: every DONE pulse is matched against the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && done_o != '0) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=%0h q=%0h, none expected (cycle %0d)",
                   done_o, q_o, cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_vec", 32'(done_o), 32'(e.done));
          chk("done_q", 32'(q_o), 32'(e.q));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    int m;
    n_cmp       = 0;
    n_bad       = 0;
    rst_i       = 1'b1;
    req_i       = '0;
    len_i       = '0;
    tick_force  = 1'b0;
    tick_sparse = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_q", 32'(q_o), 0);
    rst_i = 1'b0;
    step();

    // Round-robin: all requesters, LEN=1, TICK high
    for (int i = 0; i < NREQ; i++) len_i[i*WIDTH +: WIDTH] = 16'd1;
    tick_force = 1'b1;
    m = cyc;
    req_i = 4'b1111;
    push(4'b0001, 16'd1, m + 3);
    push(4'b0010, 16'd1, m + 7);
    push(4'b0100, 16'd1, m + 11);
    push(4'b1000, 16'd1, m + 15);
    push(4'b0001, 16'd1, m + 19);
    for (int n = 0; n < 5; n++) begin
      wait_done(n % NREQ, 20);
      chk("rr_gnt", 32'(gnt_o), 32'(1 << (n % NREQ)));
      if (n == 4) req_i = '0;
      else req_i[n % NREQ] = 1'b0;
      step();
      if (n < 4) req_i[n % NREQ] = 1'b1;
    end

    // Single request, LEN0=3
    len_i[0*WIDTH +: WIDTH] = 16'd3;
    m = cyc;
    req_i = 4'b0001;
    push(4'b0001, 16'd3, m + 5);
    step();
    chk("single_gnt", 32'(gnt_o), 32'h1);
    chk("single_busy", 32'(busy_o), 1);
    wait_done(0, 20);
    req_i = '0;
    step();
    chk("single_idle_gnt", 32'(gnt_o), 0);
    chk("single_idle_busy", 32'(busy_o), 0);
    chk("single_hold_q", 32'(q_o), 3);

    // Sparse TICK: every 3rd cycle, LEN2=4
    tick_force = 1'b0;
    while ((cyc % 3) != 1) step();
    len_i[2*WIDTH +: WIDTH] = 16'd4;
    tick_sparse = 1'b1;
    m = cyc;
    req_i = 4'b0100;
    push(4'b0100, 16'd4, m + 12);
    step_to(m + 5);
    chk("sparse_q_hold", 32'(q_o), 1);
    step_to(m + 6);
    chk("sparse_q_inc", 32'(q_o), 2);
    wait_done(2, 30);
    req_i = '0;
    tick_sparse = 1'b0;
    step();

    // Abort: requester 1 drops at Q=2, requester 2 then granted
    tick_force = 1'b1;
    len_i[1*WIDTH +: WIDTH] = 16'd10;
    m = cyc;
    req_i = 4'b0110;
    push(4'b0100, 16'd4, m + 11);
    step_to(m + 1);
    chk("abort_gnt1", 32'(gnt_o), 32'h2);
    step_to(m + 4);
    chk("abort_q2", 32'(q_o), 2);
    req_i = 4'b0100;
    step();
    chk("abort_gnt_clr", 32'(gnt_o), 0);
    chk("abort_busy_clr", 32'(busy_o), 0);
    chk("abort_q_hold", 32'(q_o), 2);
    step();
    chk("abort_next_gnt", 32'(gnt_o), 32'h4);
    wait_done(2, 20);
    req_i = '0;
    step();

    // Zero length on requester 3
    len_i[3*WIDTH +: WIDTH] = 16'd0;
    m = cyc;
    req_i = 4'b1000;
    push(4'b1000, 16'd0, m + 2);
    wait_done(3, 10);
    chk("zero_gnt_fin", 32'(gnt_o), 32'h8);
    req_i = '0;
    step();
    chk("zero_q", 32'(q_o), 0);

    // Full range, no wrap
    len_i[0*WIDTH +: WIDTH] = 16'hFFFF;
    m = cyc;
    req_i = 4'b0001;
    push(4'b0001, 16'hFFFF, m + 65537);
    wait_done(0, 70000);
    req_i = '0;
    step();
    step();
    chk("full_no_wrap", 32'(q_o), 32'hFFFF);

    // Reset mid-RUN at Q=5
    len_i[0*WIDTH +: WIDTH] = 16'd20;
    m = cyc;
    req_i = 4'b0001;
    step_to(m + 7);
    chk("pre_rst_q", 32'(q_o), 5);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt_o), 0);
    chk("mid_rst_done", 32'(done_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_q", 32'(q_o), 0);
    req_i = '0;
    step();
    rst_i = 1'b0;
    repeat (25) step();
    chk("post_rst_busy", 32'(busy_o), 0);
    chk("sb_drained", 32'(sbq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
